// File: rtl/lcd_hex_driver.sv
// HD44780 4-bit character-LCD driver: paints a 32-bit word as hex on line 1
// and, when LCD_LINE2_EN is defined, the register index as "Rnn" on line 2.
module lcd_hex_driver #(
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_WAIT_CYC  = 205000,
  parameter int E_SETUP_CYC    = 4,
  parameter int E_PULSE_CYC    = 12,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [4:0]  sel,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [3:0]  lcd_dat,
  output logic        ready,
  output logic        frame_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, INIT_WAIT_CYC), max2(E_SETUP_CYC, E_PULSE_CYC)),
                                max2(max2(NIBBLE_GAP_CYC, CMD_WAIT_CYC), CLEAR_WAIT_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

`ifdef LCD_LINE2_EN
  localparam logic [3:0] LAST_IDX = 4'd12;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic [1:0] {PWRUP, INIT, CFG, FRAME} state_t;
  typedef enum logic [2:0] {
    PH_SETUP_HI, PH_PULSE_HI, PH_GAP, PH_SETUP_LO, PH_PULSE_LO, PH_WAIT, PH_DONE
  } phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic [3:0]     idx, idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           ready_n;
  logic           latch;
  logic [31:0]    shadow_value;
  int             cur_len;
  logic [7:0]     cur_byte;
  logic           cur_rs;
  logic           in_xfer;
  logic [3:0]     digit;

`ifdef LCD_LINE2_EN
  logic [4:0]     shadow_sel;
  logic [1:0]     tens;
  logic [4:0]     rem;
`else
  logic           unused_sel;
  assign unused_sel = ^sel;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PWRUP;
      phase        <= PH_SETUP_HI;
      idx          <= '0;
      cnt          <= '0;
      ready        <= 1'b0;
      shadow_value <= '0;
`ifdef LCD_LINE2_EN
      shadow_sel   <= '0;
`endif
    end else begin
      state <= state_n;
      phase <= phase_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      ready <= ready_n;
      if (latch) begin
        shadow_value <= value;
`ifdef LCD_LINE2_EN
        shadow_sel   <= sel;
`endif
      end
    end
  end

  // Sequencer: each phase lasts cur_len cycles; the counter saturates at the
  // terminal count and is cleared as the phase advances.
  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    cnt_n   = cnt + CW'(1);
    ready_n = ready;
    latch   = 1'b0;
    cur_len = 1;

    if (state == PWRUP) begin
      cur_len = POWERUP_CYC;
    end else begin
      case (phase)
        PH_SETUP_HI, PH_SETUP_LO: cur_len = E_SETUP_CYC;
        PH_PULSE_HI, PH_PULSE_LO: cur_len = E_PULSE_CYC;
        PH_GAP:                   cur_len = NIBBLE_GAP_CYC;
        PH_WAIT: begin
          if (state == INIT && idx == 4'd0)     cur_len = INIT_WAIT_CYC;
          else if (state == CFG && idx == 4'd3) cur_len = CLEAR_WAIT_CYC;
          else                                  cur_len = CMD_WAIT_CYC;
        end
        default:                  cur_len = 1;
      endcase
    end

    if ((int'(cnt) + 1) >= cur_len) begin
      cnt_n = '0;
      if (state == PWRUP) begin
        state_n = INIT;
        idx_n   = '0;
        phase_n = PH_SETUP_LO;
      end else begin
        case (phase)
          PH_SETUP_HI: phase_n = PH_PULSE_HI;
          PH_PULSE_HI: phase_n = PH_GAP;
          PH_GAP:      phase_n = PH_SETUP_LO;
          PH_SETUP_LO: phase_n = PH_PULSE_LO;
          PH_PULSE_LO: phase_n = PH_WAIT;
          PH_WAIT: begin
            case (state)
              INIT: begin
                if (idx == 4'd3) begin
                  state_n = CFG;
                  idx_n   = '0;
                  phase_n = PH_SETUP_HI;
                end else begin
                  idx_n   = idx + 4'd1;
                  phase_n = PH_SETUP_LO;
                end
              end
              CFG: begin
                phase_n = PH_SETUP_HI;
                if (idx == 4'd3) begin
                  state_n = FRAME;
                  idx_n   = '0;
                  ready_n = 1'b1;
                  latch   = 1'b1;
                end else begin
                  idx_n   = idx + 4'd1;
                end
              end
              default: begin
                if (idx == LAST_IDX) begin
                  phase_n = PH_DONE;
                end else begin
                  idx_n   = idx + 4'd1;
                  phase_n = PH_SETUP_HI;
                end
              end
            endcase
          end
          default: begin
            idx_n   = '0;
            phase_n = PH_SETUP_HI;
            latch   = 1'b1;
          end
        endcase
      end
    end
  end

  // Byte currently on the bus; init nibbles sit in the low half because
  // they enter the transfer at the low-nibble setup.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    digit    = 4'h0;
`ifdef LCD_LINE2_EN
    tens     = 2'd0;
    rem      = shadow_sel;
    if (shadow_sel >= 5'd30)      begin tens = 2'd3; rem = shadow_sel - 5'd30; end
    else if (shadow_sel >= 5'd20) begin tens = 2'd2; rem = shadow_sel - 5'd20; end
    else if (shadow_sel >= 5'd10) begin tens = 2'd1; rem = shadow_sel - 5'd10; end
`endif
    case (idx)
      4'd1: digit = shadow_value[31:28];
      4'd2: digit = shadow_value[27:24];
      4'd3: digit = shadow_value[23:20];
      4'd4: digit = shadow_value[19:16];
      4'd5: digit = shadow_value[15:12];
      4'd6: digit = shadow_value[11:8];
      4'd7: digit = shadow_value[7:4];
      default: digit = shadow_value[3:0];
    endcase
    case (state)
      INIT: begin
        case (idx)
          4'd3:    cur_byte = 8'h02;
          default: cur_byte = 8'h03;
        endcase
      end
      CFG: begin
        case (idx)
          4'd0:    cur_byte = 8'h28;
          4'd1:    cur_byte = 8'h06;
          4'd2:    cur_byte = 8'h0C;
          default: cur_byte = 8'h01;
        endcase
      end
      FRAME: begin
        if (idx == 4'd0) begin
          cur_byte = 8'h80;
        end else if (idx <= 4'd8) begin
          cur_byte = hex_char(digit);
          cur_rs   = 1'b1;
`ifdef LCD_LINE2_EN
        end else if (idx == 4'd9) begin
          cur_byte = 8'hC0;
        end else if (idx == 4'd10) begin
          cur_byte = 8'h52;
          cur_rs   = 1'b1;
        end else if (idx == 4'd11) begin
          cur_byte = {6'b001100, tens};
          cur_rs   = 1'b1;
        end else begin
          cur_byte = {4'h3, rem[3:0]};
          cur_rs   = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign in_xfer    = (state != PWRUP) && (phase != PH_WAIT) && (phase != PH_DONE);
  assign lcd_e      = (state != PWRUP) && ((phase == PH_PULSE_HI) || (phase == PH_PULSE_LO));
  assign lcd_rs     = in_xfer ? cur_rs : 1'b0;
  assign lcd_dat    = !in_xfer ? 4'h0 :
                      ((phase == PH_SETUP_LO) || (phase == PH_PULSE_LO)) ? cur_byte[3:0] : cur_byte[7:4];
  assign lcd_rw     = 1'b0;
  assign frame_done = (state == FRAME) && (phase == PH_DONE);

endmodule
